// File: rtl/mux41_pkg.sv
// Shared types and constants for the mux41 round-robin arbiter family.
// Holds the state encoding, requester count and select width.
package mux41_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    typedef logic [SEL_W-1:0]   sel_t;
    typedef logic [NUM_REQ-1:0] req_t;

    function automatic req_t onehot(input sel_t idx);
        return req_t'(1) << idx;
    endfunction

endpackage

// File: rtl/mux41_rr_arbiter_if.sv
// Request/grant bundle between the four requesters and the arbiter.
// The arbiter is the slave side; the requester side (or a bench) is the master.
interface mux41_rr_arbiter_if #(
    parameter int CNT_W = 4
);
    import mux41_pkg::*;

    req_t             req;
    req_t             gnt;
    logic             s0;
    logic             s1;
    logic             busy;
    logic [CNT_W-1:0] hold_cnt;

    modport master (
        output req,
        input  gnt, s0, s1, busy, hold_cnt
    );

    modport slave (
        input  req,
        output gnt, s0, s1, busy, hold_cnt
    );

endinterface

// File: rtl/mux41_rr_arbiter_rr_pick4.sv
// Combinational 4-way round-robin priority encoder: scans last+1, last+2, ...
// (mod 4) and reports the first asserted request.
module rr_pick4
    import mux41_pkg::*;
(
    input  req_t req,
    input  sel_t last,
    output sel_t winner,
    output logic any
);

    sel_t idx;

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        // Walk from lowest to highest priority so the nearest hit overwrites the rest.
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last + SEL_W'(k);
            if (req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin owner of the mux41 select lines: grants one of four requesters,
// drives {s1,s0} to its index and releases on request drop or hold limit.
module mux41_rr_arbiter
    import mux41_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input logic                clk,
    input logic                rst_n,
    mux41_rr_arbiter_if.slave  bus
);

    localparam logic             HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(MAX_HOLD - 1);

    state_e           state_q;
    req_t             gnt_q;
    sel_t             sel_q;
    logic             busy_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;
    sel_t             last_q;

    sel_t pick_winner;
    logic pick_any;
    logic release_hit;

    rr_pick4 u_pick (
        .req    (bus.req),
        .last   (last_q),
        .winner (pick_winner),
        .any    (pick_any)
    );

    // A drop and a limit hit on the same edge collapse into one release.
    assign release_hit = !bus.req[sel_q] || (HOLD_LIMITED && (hold_cnt_q == HOLD_LAST));
    assign hold_cnt_d  = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
            last_q     <= sel_t'(NUM_REQ - 1);
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_q    <= ST_GRANT;
                        gnt_q      <= onehot(pick_winner);
                        sel_q      <= pick_winner;
                        busy_q     <= 1'b1;
                        hold_cnt_q <= '0;
                        last_q     <= pick_winner;
                    end
                end
                ST_GRANT: begin
                    // Select lines are left alone on release to avoid a mux glitch.
                    if (release_hit) begin
                        state_q    <= ST_IDLE;
                        gnt_q      <= '0;
                        busy_q     <= 1'b0;
                        hold_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_d;
                    end
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.s0       = sel_q[0];
    assign bus.s1       = sel_q[1];
    assign bus.busy     = busy_q;
    assign bus.hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Self-checking bench for mux41_rr_arbiter: scoreboard-driven checks on a
// MAX_HOLD=8 instance plus directed checks on an unlimited-hold instance.
module tb_mux41_rr_arbiter;

    localparam int MH8 = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mux41_rr_arbiter_if #(.CNT_W(4)) if8 ();
    mux41_rr_arbiter_if #(.CNT_W(4)) if0 ();

    mux41_rr_arbiter #(.MAX_HOLD(MH8), .CNT_W(4)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    mux41_rr_arbiter #(.MAX_HOLD(0), .CNT_W(4)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int m_busy, m_sel, m_last, m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_sel  = 0;
        m_last = 3;
        m_cnt  = 0;
    endtask

    // Reference behaviour of the MAX_HOLD=8 instance for one clock edge.
    task automatic model_step(input logic [3:0] r);
        exp_t e;
        int   i;
        bit   found;
        found = 1'b0;
        if (m_busy == 0) begin
            for (int k = 1; k <= 4; k++) begin
                i = (m_last + k) % 4;
                if (r[i] && !found) begin
                    found  = 1'b1;
                    m_busy = 1;
                    m_sel  = i;
                    m_last = i;
                    m_cnt  = 0;
                end
            end
        end else begin
            if (r[m_sel] == 1'b0 || m_cnt == MH8 - 1) begin
                m_busy = 0;
                m_cnt  = 0;
            end else if (m_cnt < 15) begin
                m_cnt++;
            end
        end
        e.gnt  = (m_busy != 0) ? 4'(1 << m_sel) : 4'b0000;
        e.sel  = 2'(m_sel);
        e.busy = (m_busy != 0);
        e.cnt  = 4'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic [3:0] r);
        exp_t e;
        if8.req = r;
        model_step(r);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("sb_gnt",  32'(if8.gnt),                e.gnt);
        check("sb_sel",  32'({if8.s1, if8.s0}),       e.sel);
        check("sb_busy", 32'(if8.busy),               e.busy);
        check("sb_cnt",  32'(if8.hold_cnt),           e.cnt);
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        if8.req = 4'b0000;
        if0.req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt",  32'(if8.gnt),      0);
        check("rst_s1",   32'(if8.s1),       0);
        check("rst_s0",   32'(if8.s0),       0);
        check("rst_busy", 32'(if8.busy),     0);
        check("rst_cnt",  32'(if8.hold_cnt), 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int order[$];
        int exp_order[5];
        int busy_cycles;
        int max_cnt;
        logic prev_busy;

        exp_order = '{0, 1, 2, 3, 0};
        rst_n   = 1'b0;
        if8.req = 4'b0000;
        if0.req = 4'b0000;
        #1;

        // Reset then a single request from requester 2.
        apply_reset();
        cycle(4'b0100);
        check("single_gnt",  32'(if8.gnt),  32'b0100);
        check("single_s1",   32'(if8.s1),   1);
        check("single_s0",   32'(if8.s0),   0);
        check("single_busy", 32'(if8.busy), 1);
        cycle(4'b0000);
        check("drop_gnt", 32'(if8.gnt),  0);
        check("drop_s1",  32'(if8.s1),   1);
        check("drop_s0",  32'(if8.s0),   0);
        cycle(4'b0000);

        // Fairness with all four requesting.
        apply_reset();
        prev_busy   = 1'b0;
        busy_cycles = 0;
        max_cnt     = 0;
        repeat (40) begin
            cycle(4'b1111);
            if (if8.busy && !prev_busy) order.push_back(int'({if8.s1, if8.s0}));
            if (if8.busy) begin
                busy_cycles++;
                if (int'(if8.hold_cnt) > max_cnt) max_cnt = int'(if8.hold_cnt);
            end
            prev_busy = if8.busy;
        end
        check("rr_grants", order.size(), 5);
        for (int j = 0; j < 5; j++) begin
            if (j < order.size()) check($sformatf("rr_order%0d", j), order[j], exp_order[j]);
            else check($sformatf("rr_order%0d", j), 32'hffff_ffff, exp_order[j]);
        end
        check("rr_busy_cycles", busy_cycles, 36);
        check("rr_max_cnt", max_cnt, 7);
        cycle(4'b0000);

        // Priority rotation: after owner 1, scan starts at 2 and wraps to 0.
        apply_reset();
        cycle(4'b0010);
        cycle(4'b0000);
        cycle(4'b0011);
        check("rot_gnt", 32'(if8.gnt), 32'b0001);
        check("rot_sel", 32'({if8.s1, if8.s0}), 0);
        cycle(4'b0000);

        // Owner 2 drops its request on the same edge the hold limit hits.
        apply_reset();
        cycle(4'b0100);
        repeat (7) cycle(4'b1100);
        check("coll_cnt", 32'(if8.hold_cnt), 7);
        cycle(4'b1000);
        check("coll_rel_gnt",  32'(if8.gnt),  0);
        check("coll_rel_busy", 32'(if8.busy), 0);
        cycle(4'b1000);
        check("coll_next_gnt", 32'(if8.gnt), 32'b1000);
        check("coll_next_sel", 32'({if8.s1, if8.s0}), 3);

        // Asynchronous reset in the middle of owner 3's grant.
        repeat (5) cycle(4'b1000);
        check("arst_pre_cnt", 32'(if8.hold_cnt), 5);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_gnt",  32'(if8.gnt),      0);
        check("arst_busy", 32'(if8.busy),     0);
        check("arst_s1",   32'(if8.s1),       0);
        check("arst_s0",   32'(if8.s0),       0);
        check("arst_cnt",  32'(if8.hold_cnt), 0);
        #1;
        rst_n = 1'b1;
        model_reset();
        cycle(4'b1000);
        check("arst_regnt", 32'(if8.gnt), 32'b1000);
        check("sb_empty", exp_q.size(), 0);

        // Unlimited hold: requester 0 keeps the channel, others starve.
        if8.req = 4'b0000;
        if0.req = 4'b0001;
        @(posedge clk);
        #1;
        check("unl_gnt0", 32'(if0.gnt),      32'b0001);
        check("unl_cnt0", 32'(if0.hold_cnt), 0);
        if0.req = 4'b1111;
        repeat (39) @(posedge clk);
        #1;
        check("unl_gnt",  32'(if0.gnt),      32'b0001);
        check("unl_busy", 32'(if0.busy),     1);
        check("unl_sat",  32'(if0.hold_cnt), 15);
        if0.req = 4'b1110;
        @(posedge clk);
        #1;
        check("unl_rel_gnt", 32'(if0.gnt),      0);
        check("unl_rel_cnt", 32'(if0.hold_cnt), 0);
        @(posedge clk);
        #1;
        check("unl_next_gnt", 32'(if0.gnt), 32'b0010);
        check("unl_next_sel", 32'({if0.s1, if0.s0}), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
